// File: rtl/softplus_rr_sched_pkg.sv
// Shared constants and helpers for the round-robin softplus scheduler.
// Operands and results are Q8.8 signed fixed point (8 integer bits, 8 fraction bits).
package softplus_rr_sched_pkg;

    localparam int unsigned DefNReq    = 4;
    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefPipeLat = 4;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/softplus_rr_sched_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps around.
// The pointer register lives in the parent; this block only reports the winner
// and the pointer value to load if the grant is taken.
module softplus_rr_sched_arbiter
    import softplus_rr_sched_pkg::*;
#(
    parameter int unsigned N    = DefNReq,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic            en,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic [IdxW-1:0] next_ptr
);

    logic [IdxW-1:0] cand;

    // First requester at or after ptr wins; nothing is granted while disabled.
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxW'((32'(ptr) + k) % N);
            if (en && !gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt      = gnt_valid ? (N'(1) << gnt_idx) : '0;
        next_ptr = IdxW'(rr_wrap_inc(32'(gnt_idx), N));
    end

endmodule

// File: rtl/softplus_rr_sched.sv
// Shares one pipelined softplus datapath between N_REQ requesters.
// One operand is admitted per cycle by round-robin; a tag shift register that
// runs alongside the external pipe routes each result back with a one-hot strobe.
module softplus_rr_sched
    import softplus_rr_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = DefNReq,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned PIPE_LAT = DefPipeLat
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      drain,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         sp_in,
    input  logic [DATA_W-1:0]         sp_out,
    output logic [N_REQ-1:0]          res_valid,
    output logic [DATA_W-1:0]         res_data,
    output logic                      busy
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic [IdxW-1:0]   gnt_next_ptr;
    logic              gnt_valid;
    logic              grant_en;

    logic [DATA_W-1:0] sp_in_q, sp_in_d;
    logic [PIPE_LAT:0] vld_sr_q, vld_sr_d;
    logic [IdxW-1:0]   id_sr_q [PIPE_LAT+1];
    logic [IdxW-1:0]   id_sr_d [PIPE_LAT+1];
    logic [N_REQ-1:0]  res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              busy_q, busy_d;

    assign grant_en = en & ~drain;

    softplus_rr_sched_arbiter #(
        .N    (N_REQ),
        .IdxW (IdxW)
    ) u_arbiter (
        .req       (req_valid),
        .en        (grant_en),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .next_ptr  (gnt_next_ptr)
    );

    // Issue, tag tracking and result routing for the next cycle.
    always_comb begin
        // The grant is only ever given to a valid requester, so a grant is a transfer.
        ptr_d   = gnt_valid ? gnt_next_ptr : ptr_q;
        sp_in_d = gnt_valid ? req_data[32'(gnt_idx)*DATA_W +: DATA_W] : '0;

        // Stage 0 is loaded with sp_in; stage PIPE_LAT lines up with sp_out.
        vld_sr_d   = {vld_sr_q[PIPE_LAT-1:0], gnt_valid};
        id_sr_d[0] = gnt_idx;
        for (int unsigned s = 1; s <= PIPE_LAT; s++) begin
            id_sr_d[s] = id_sr_q[s-1];
        end

        res_valid_d = vld_sr_q[PIPE_LAT] ? (N_REQ'(1) << id_sr_q[PIPE_LAT]) : '0;
        res_data_d  = sp_out;
        busy_d      = |vld_sr_d;
    end

    // State registers; reset drops any in-flight samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            sp_in_q     <= '0;
            vld_sr_q    <= '0;
            for (int unsigned s = 0; s <= PIPE_LAT; s++) begin
                id_sr_q[s] <= '0;
            end
            res_valid_q <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            sp_in_q     <= sp_in_d;
            vld_sr_q    <= vld_sr_d;
            for (int unsigned s = 0; s <= PIPE_LAT; s++) begin
                id_sr_q[s] <= id_sr_d[s];
            end
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = gnt;
    assign sp_in     = sp_in_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softplus_rr_sched.sv
// Self-checking bench for softplus_rr_sched with a delay-line stand-in for the softplus pipe.
module tb_softplus_rr_sched;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 16;
    localparam int PIPE_LAT = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    en = 1'b0;
    logic                    drain = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       sp_in;
    logic [DATA_W-1:0]       sp_out;
    logic [N_REQ-1:0]        res_valid;
    logic [DATA_W-1:0]       res_data;
    logic                    busy;

    softplus_rr_sched #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .drain     (drain),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sp_in     (sp_in),
        .sp_out    (sp_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in transfer function: offset by ln2 in Q8.8, easy to predict.
    function automatic logic [DATA_W-1:0] sp_model(input logic [DATA_W-1:0] x);
        return x + 16'h00B1;
    endfunction

    // PIPE_LAT register stages between sp_in and sp_out.
    logic [DATA_W-1:0] pipe [PIPE_LAT];
    always @(posedge clk) begin
        pipe[0] <= sp_in;
        for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sp_out = sp_model(pipe[PIPE_LAT-1]);

    // Reference model: expected results as (due edge, requester, operand).
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    int                m_ptr = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] m_sp_in = '0;
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Winner by the rotation rule, or -1 if none.
    function automatic int model_grant(input logic [N_REQ-1:0] v, input logic allow);
        if (!allow) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N_REQ-1:0] ev;
        ev = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = N_REQ'(1) << exp_q[0].id;
            check_eq("res_data", res_data, sp_model(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        check_eq("res_valid", res_valid, ev);
        check_eq("sp_in", sp_in, m_sp_in);
        check_eq("busy", busy, exp_q.size() > 0);
    endtask

    // One clock cycle: drive, check grant, advance model at the edge, check outputs.
    task automatic step(input logic [N_REQ-1:0] v, input logic [N_REQ*DATA_W-1:0] d,
                        input logic e, input logic dr);
        int               g;
        logic [N_REQ-1:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        en        = e;
        drain     = dr;
        #1;
        g       = model_grant(v, e && !dr);
        exp_rdy = (g >= 0) ? (N_REQ'(1) << g) : '0;
        check_eq("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            exp_q.push_back('{due: cyc + PIPE_LAT + 1, id: g, data: d[g*DATA_W +: DATA_W]});
            m_ptr   = (g + 1) % N_REQ;
            m_sp_in = d[g*DATA_W +: DATA_W];
        end else begin
            m_sp_in = '0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [N_REQ*DATA_W-1:0] rand_data();
        logic [N_REQ*DATA_W-1:0] d;
        for (int i = 0; i < N_REQ; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return d;
    endfunction

    // Asserts reset between edges, checks the immediate clear, holds, releases at a negedge.
    task automatic apply_reset(input int hold);
        req_valid = '0;
        en        = 1'b0;
        drain     = 1'b0;
        #2 reset  = 1'b0;
        #1;
        check_eq("rst_res_valid", res_valid, '0);
        check_eq("rst_res_data", res_data, '0);
        check_eq("rst_sp_in", sp_in, '0);
        check_eq("rst_busy", busy, 1'b0);
        exp_q.delete();
        m_ptr   = 0;
        m_sp_in = '0;
        repeat (hold) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_eq("rst_hold_res_valid", res_valid, '0);
            check_eq("rst_hold_busy", busy, 1'b0);
            check_eq("rst_hold_sp_in", sp_in, '0);
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [N_REQ*DATA_W-1:0] d;

        // 1: reset held, then idle with nothing requested.
        @(negedge clk);
        apply_reset(5);
        repeat (5) step('0, rand_data(), 1'b1, 1'b0);

        // 2: single request from requester 2.
        d = rand_data();
        d[2*DATA_W +: DATA_W] = 16'h0314;
        step(4'b0100, d, 1'b1, 1'b0);
        repeat (7) step('0, rand_data(), 1'b1, 1'b0);

        // 3: all requesters valid for 8 cycles.
        repeat (8) step(4'b1111, rand_data(), 1'b1, 1'b0);
        repeat (7) step('0, rand_data(), 1'b1, 1'b0);

        // 4: requester 1 alone, then 1 and 3 together.
        repeat (3) step(4'b0010, rand_data(), 1'b1, 1'b0);
        repeat (6) step(4'b1010, rand_data(), 1'b1, 1'b0);
        repeat (7) step('0, rand_data(), 1'b1, 1'b0);

        // 5: drain with three samples in flight, then resume at the frozen pointer.
        repeat (3) step(4'b1111, rand_data(), 1'b1, 1'b0);
        repeat (9) step(4'b1111, rand_data(), 1'b1, 1'b1);
        repeat (4) step(4'b1111, rand_data(), 1'b1, 1'b0);
        repeat (3) step(4'b1111, rand_data(), 1'b0, 1'b0);
        repeat (7) step('0, rand_data(), 1'b1, 1'b0);

        // 6: reset with four samples in flight; nothing may emerge afterwards.
        repeat (4) step(4'b1111, rand_data(), 1'b1, 1'b0);
        apply_reset(2);
        repeat (8) step('0, rand_data(), 1'b1, 1'b0);
        step(4'b1010, rand_data(), 1'b1, 1'b0);
        repeat (7) step('0, rand_data(), 1'b1, 1'b0);

        // Randomised traffic with occasional disable and drain.
        for (int n = 0; n < 400; n++) begin
            step(N_REQ'($urandom), rand_data(), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) == 0));
        end
        repeat (8) step('0, rand_data(), 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
